inst_queue_decoder: RTL and testbench

//  Instruction queue plus RV32I decoder. Sits between the instruction fetcher and the RS/LSB/ROB dispatch logic.

---
 rtl/inst_queue_decoder.sv | 324 ++++++++++++++++++++++++++++++++
 tb/tb_inst_queue_decoder.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_queue_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : inst_queue_decoder (with inst_queue_decoder_pkg)
//  Brief    : Circular instruction queue of {pc, inst} pairs with a
//             combinational RV32I decoder on the head entry, valid/ready
//             handshakes on both sides and a mispredict flush.
//  Revision : 1.0 - initial release
// ============================================================================

package inst_queue_decoder_pkg;
    localparam int OPENUM_WIDTH = 6;

    localparam logic [OPENUM_WIDTH-1:0] OPENUM_NOP   = 6'd0;
    localparam logic [OPENUM_WIDTH-1:0] OPENUM_LUI   = 6'd1;
    localparam logic [OPENUM_WIDTH-1:0] OPENUM_AUIPC = 6'd2;
    localparam logic [OPENUM_WIDTH-1:0] OPENUM_JAL   = 6'd3;
    localparam logic [OPENUM_WIDTH-1:0] OPENUM_JALR  = 6'd4;
    localparam logic [OPENUM_WIDTH-1:0] OPENUM_BEQ   = 6'd5;
    localparam logic [OPENUM_WIDTH-1:0] OPENUM_BNE   = 6'd6;
    localparam logic [OPENUM_WIDTH-1:0] OPENUM_BLT   = 6'd7;
    localparam logic [OPENUM_WIDTH-1:0] OPENUM_BGE   = 6'd8;
    localparam logic [OPENUM_WIDTH-1:0] OPENUM_BLTU  = 6'd9;
    localparam logic [OPENUM_WIDTH-1:0] OPENUM_BGEU  = 6'd10;
    localparam logic [OPENUM_WIDTH-1:0] OPENUM_LB    = 6'd11;
    localparam logic [OPENUM_WIDTH-1:0] OPENUM_LH    = 6'd12;
    localparam logic [OPENUM_WIDTH-1:0] OPENUM_LW    = 6'd13;
    localparam logic [OPENUM_WIDTH-1:0] OPENUM_LBU   = 6'd14;
    localparam logic [OPENUM_WIDTH-1:0] OPENUM_LHU   = 6'd15;
    localparam logic [OPENUM_WIDTH-1:0] OPENUM_SB    = 6'd16;
    localparam logic [OPENUM_WIDTH-1:0] OPENUM_SH    = 6'd17;
    localparam logic [OPENUM_WIDTH-1:0] OPENUM_SW    = 6'd18;
    localparam logic [OPENUM_WIDTH-1:0] OPENUM_ADDI  = 6'd19;
    localparam logic [OPENUM_WIDTH-1:0] OPENUM_SLTI  = 6'd20;
    localparam logic [OPENUM_WIDTH-1:0] OPENUM_SLTIU = 6'd21;
    localparam logic [OPENUM_WIDTH-1:0] OPENUM_XORI  = 6'd22;
    localparam logic [OPENUM_WIDTH-1:0] OPENUM_ORI   = 6'd23;
    localparam logic [OPENUM_WIDTH-1:0] OPENUM_ANDI  = 6'd24;
    localparam logic [OPENUM_WIDTH-1:0] OPENUM_SLLI  = 6'd25;
    localparam logic [OPENUM_WIDTH-1:0] OPENUM_SRLI  = 6'd26;
    localparam logic [OPENUM_WIDTH-1:0] OPENUM_SRAI  = 6'd27;
    localparam logic [OPENUM_WIDTH-1:0] OPENUM_ADD   = 6'd28;
    localparam logic [OPENUM_WIDTH-1:0] OPENUM_SUB   = 6'd29;
    localparam logic [OPENUM_WIDTH-1:0] OPENUM_SLL   = 6'd30;
    localparam logic [OPENUM_WIDTH-1:0] OPENUM_SLT   = 6'd31;
    localparam logic [OPENUM_WIDTH-1:0] OPENUM_SLTU  = 6'd32;
    localparam logic [OPENUM_WIDTH-1:0] OPENUM_XOR   = 6'd33;
    localparam logic [OPENUM_WIDTH-1:0] OPENUM_SRL   = 6'd34;
    localparam logic [OPENUM_WIDTH-1:0] OPENUM_SRA   = 6'd35;
    localparam logic [OPENUM_WIDTH-1:0] OPENUM_OR    = 6'd36;
    localparam logic [OPENUM_WIDTH-1:0] OPENUM_AND   = 6'd37;
endpackage

module inst_queue_decoder
    import inst_queue_decoder_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic                    clear_in,
    input  logic                    in_valid,
    input  logic [31:0]             in_inst,
    input  logic [ADDR_WIDTH-1:0]   in_pc,
    output logic                    in_ready,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ADDR_WIDTH-1:0]   out_pc,
    output logic [OPENUM_WIDTH-1:0] out_openum,
    output logic [4:0]              out_rd,
    output logic [4:0]              out_rs1,
    output logic [4:0]              out_rs2,
    output logic [31:0]             out_imm,
    output logic                    out_is_ctrl,
    output logic                    out_is_ls,
    output logic                    out_is_store,
    output logic                    out_illegal
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = ADDR_WIDTH + 32;
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

    localparam logic [6:0] C_OP_LUI    = 7'b0110111;
    localparam logic [6:0] C_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] C_OP_JAL    = 7'b1101111;
    localparam logic [6:0] C_OP_JALR   = 7'b1100111;
    localparam logic [6:0] C_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] C_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] C_OP_STORE  = 7'b0100011;
    localparam logic [6:0] C_OP_ARITHI = 7'b0010011;
    localparam logic [6:0] C_OP_ARITH  = 7'b0110011;
    localparam logic [6:0] C_F7_ALT    = 7'b0100000;

    logic [EW-1:0] mem [DEPTH];

    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic w_push;
    logic w_pop;

    assign in_ready  = (count_q < C_DEPTH);
    assign out_valid = (count_q != '0);

    // Handshake qualification; flush and global stall both suppress transfers.
    always_comb begin
        w_push = in_valid && in_ready && rdy_in && !clear_in;
        w_pop  = out_valid && out_ready && rdy_in && !clear_in;
    end

    // Next-state pointers and occupancy; a flush empties the queue outright.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (rdy_in && clear_in) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (w_push) tail_d = tail_q + 1'b1;
            if (w_pop)  head_d = head_q + 1'b1;
            case ({w_push, w_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents need no reset since occupancy gates visibility.
    always_ff @(posedge clk_in) begin
        if (!rst_in && w_push) begin
            mem[tail_q] <= {in_pc, in_inst};
        end
    end

    logic [EW-1:0]         w_entry;
    logic [31:0]           w_inst;
    logic [ADDR_WIDTH-1:0] w_pc;
    logic [2:0]            w_f3;
    logic                  w_f7_alt;
    logic [31:0]           w_imm_i;
    logic [31:0]           w_imm_s;
    logic [31:0]           w_imm_b;
    logic [31:0]           w_imm_u;
    logic [31:0]           w_imm_j;
    logic [31:0]           w_imm_sh;

    assign w_entry  = mem[head_q];
    assign w_inst   = w_entry[31:0];
    assign w_pc     = w_entry[EW-1:32];
    assign w_f3     = w_inst[14:12];
    assign w_f7_alt = (w_inst[31:25] == C_F7_ALT);
    assign w_imm_i  = {{20{w_inst[31]}}, w_inst[31:20]};
    assign w_imm_s  = {{20{w_inst[31]}}, w_inst[31:25], w_inst[11:7]};
    assign w_imm_b  = {{19{w_inst[31]}}, w_inst[31], w_inst[7], w_inst[30:25], w_inst[11:8], 1'b0};
    assign w_imm_u  = {w_inst[31:12], 12'b0};
    assign w_imm_j  = {{11{w_inst[31]}}, w_inst[31], w_inst[19:12], w_inst[20], w_inst[30:21], 1'b0};
    assign w_imm_sh = {27'b0, w_inst[24:20]};

    logic [OPENUM_WIDTH-1:0] w_openum;
    logic [4:0]              w_rd;
    logic [31:0]             w_imm;
    logic                    w_is_ctrl;
    logic                    w_is_ls;
    logic                    w_is_store;
    logic                    w_illegal;

    // RV32I decode of the head entry; illegal encodings collapse to a NOP.
    always_comb begin
        w_openum   = OPENUM_NOP;
        w_rd       = w_inst[11:7];
        w_imm      = '0;
        w_is_ctrl  = 1'b0;
        w_is_ls    = 1'b0;
        w_is_store = 1'b0;
        w_illegal  = 1'b0;
        case (w_inst[6:0])
            C_OP_LUI: begin
                w_openum = OPENUM_LUI;
                w_imm    = w_imm_u;
            end
            C_OP_AUIPC: begin
                w_openum = OPENUM_AUIPC;
                w_imm    = w_imm_u;
            end
            C_OP_JAL: begin
                w_openum  = OPENUM_JAL;
                w_imm     = w_imm_j;
                w_is_ctrl = 1'b1;
            end
            C_OP_JALR: begin
                w_openum  = OPENUM_JALR;
                w_imm     = w_imm_i;
                w_is_ctrl = 1'b1;
            end
            C_OP_LOAD: begin
                w_imm   = w_imm_i;
                w_is_ls = 1'b1;
                case (w_f3)
                    3'd0:    w_openum  = OPENUM_LB;
                    3'd1:    w_openum  = OPENUM_LH;
                    3'd2:    w_openum  = OPENUM_LW;
                    3'd4:    w_openum  = OPENUM_LBU;
                    3'd5:    w_openum  = OPENUM_LHU;
                    default: w_illegal = 1'b1;
                endcase
            end
            C_OP_ARITHI: begin
                w_imm = w_imm_i;
                case (w_f3)
                    3'd0: w_openum = OPENUM_ADDI;
                    3'd2: w_openum = OPENUM_SLTI;
                    3'd3: w_openum = OPENUM_SLTIU;
                    3'd4: w_openum = OPENUM_XORI;
                    3'd6: w_openum = OPENUM_ORI;
                    3'd7: w_openum = OPENUM_ANDI;
                    3'd1: begin
                        w_openum = OPENUM_SLLI;
                        w_imm    = w_imm_sh;
                    end
                    default: begin
                        w_openum = w_f7_alt ? OPENUM_SRAI : OPENUM_SRLI;
                        w_imm    = w_imm_sh;
                    end
                endcase
            end
            C_OP_BRANCH: begin
                w_rd      = '0;
                w_imm     = w_imm_b;
                w_is_ctrl = 1'b1;
                case (w_f3)
                    3'd0:    w_openum  = OPENUM_BEQ;
                    3'd1:    w_openum  = OPENUM_BNE;
                    3'd4:    w_openum  = OPENUM_BLT;
                    3'd5:    w_openum  = OPENUM_BGE;
                    3'd6:    w_openum  = OPENUM_BLTU;
                    3'd7:    w_openum  = OPENUM_BGEU;
                    default: w_illegal = 1'b1;
                endcase
            end
            C_OP_STORE: begin
                w_rd       = '0;
                w_imm      = w_imm_s;
                w_is_ls    = 1'b1;
                w_is_store = 1'b1;
                case (w_f3)
                    3'd0:    w_openum  = OPENUM_SB;
                    3'd1:    w_openum  = OPENUM_SH;
                    3'd2:    w_openum  = OPENUM_SW;
                    default: w_illegal = 1'b1;
                endcase
            end
            C_OP_ARITH: begin
                case (w_f3)
                    3'd0:    w_openum = w_f7_alt ? OPENUM_SUB : OPENUM_ADD;
                    3'd1:    w_openum = OPENUM_SLL;
                    3'd2:    w_openum = OPENUM_SLT;
                    3'd3:    w_openum = OPENUM_SLTU;
                    3'd4:    w_openum = OPENUM_XOR;
                    3'd5:    w_openum = w_f7_alt ? OPENUM_SRA : OPENUM_SRL;
                    3'd6:    w_openum = OPENUM_OR;
                    default: w_openum = OPENUM_AND;
                endcase
            end
            default: w_illegal = 1'b1;
        endcase

        if (w_illegal) begin
            w_openum   = OPENUM_NOP;
            w_rd       = '0;
            w_imm      = '0;
            w_is_ctrl  = 1'b0;
            w_is_ls    = 1'b0;
            w_is_store = 1'b0;
        end
    end

    // Present zeros while empty so stale storage never leaks to dispatch.
    always_comb begin
        out_pc       = '0;
        out_openum   = OPENUM_NOP;
        out_rd       = '0;
        out_rs1      = '0;
        out_rs2      = '0;
        out_imm      = '0;
        out_is_ctrl  = 1'b0;
        out_is_ls    = 1'b0;
        out_is_store = 1'b0;
        out_illegal  = 1'b0;
        if (out_valid) begin
            out_pc       = w_pc;
            out_openum   = w_openum;
            out_rd       = w_rd;
            out_rs1      = w_inst[19:15];
            out_rs2      = w_inst[24:20];
            out_imm      = w_imm;
            out_is_ctrl  = w_is_ctrl;
            out_is_ls    = w_is_ls;
            out_is_store = w_is_store;
            out_illegal  = w_illegal;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_inst_queue_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_inst_queue_decoder
//  Brief    : Self-checking bench for inst_queue_decoder; a queue-based
//             reference model with table-driven RV32I decode.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_inst_queue_decoder;
    import inst_queue_decoder_pkg::*;

    localparam int DEPTH = 16;
    localparam int AW    = 32;

    logic                    clk_in = 1'b0;
    logic                    rst_in, rdy_in, clear_in, in_valid, out_ready;
    logic [31:0]             in_inst;
    logic [AW-1:0]           in_pc;
    logic                    in_ready, out_valid;
    logic [AW-1:0]           out_pc;
    logic [OPENUM_WIDTH-1:0] out_openum;
    logic [4:0]              out_rd, out_rs1, out_rs2;
    logic [31:0]             out_imm;
    logic                    out_is_ctrl, out_is_ls, out_is_store, out_illegal;

    always #5 clk_in = ~clk_in;

    inst_queue_decoder #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .rdy_in      (rdy_in),
        .clear_in    (clear_in),
        .in_valid    (in_valid),
        .in_inst     (in_inst),
        .in_pc       (in_pc),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_openum  (out_openum),
        .out_rd      (out_rd),
        .out_rs1     (out_rs1),
        .out_rs2     (out_rs2),
        .out_imm     (out_imm),
        .out_is_ctrl (out_is_ctrl),
        .out_is_ls   (out_is_ls),
        .out_is_store(out_is_store),
        .out_illegal (out_illegal)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Mnemonic tables indexed by funct3; NOP marks an unused slot.
    localparam logic [5:0] LOAD_OPS [8] = '{OPENUM_LB, OPENUM_LH, OPENUM_LW, OPENUM_NOP,
                                           OPENUM_LBU, OPENUM_LHU, OPENUM_NOP, OPENUM_NOP};
    localparam logic [5:0] BR_OPS   [8] = '{OPENUM_BEQ, OPENUM_BNE, OPENUM_NOP, OPENUM_NOP,
                                           OPENUM_BLT, OPENUM_BGE, OPENUM_BLTU, OPENUM_BGEU};
    localparam logic [5:0] ST_OPS   [8] = '{OPENUM_SB, OPENUM_SH, OPENUM_SW, OPENUM_NOP,
                                           OPENUM_NOP, OPENUM_NOP, OPENUM_NOP, OPENUM_NOP};
    localparam logic [5:0] AI_OPS   [8] = '{OPENUM_ADDI, OPENUM_SLLI, OPENUM_SLTI, OPENUM_SLTIU,
                                           OPENUM_XORI, OPENUM_SRLI, OPENUM_ORI, OPENUM_ANDI};
    localparam logic [5:0] AR_OPS   [8] = '{OPENUM_ADD, OPENUM_SLL, OPENUM_SLT, OPENUM_SLTU,
                                           OPENUM_XOR, OPENUM_SRL, OPENUM_OR, OPENUM_AND};

    typedef struct packed {
        logic [5:0]  op;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        ctrl;
        logic        ls;
        logic        st;
        logic        ill;
        logic        unk;
    } ref_t;

    function automatic ref_t ref_decode(input logic [31:0] w);
        ref_t r;
        logic signed [11:0] i12;
        logic signed [11:0] s12;
        logic signed [12:0] b13;
        logic signed [20:0] j21;
        int   f3;
        logic alt;
        i12 = w[31:20];
        s12 = {w[31:25], w[11:7]};
        b13 = {w[31], w[7], w[30:25], w[11:8], 1'b0};
        j21 = {w[31], w[19:12], w[20], w[30:21], 1'b0};
        f3  = int'(w[14:12]);
        alt = (w[31:25] == 7'h20);
        r   = '0;
        r.rd = w[11:7];
        case (w[6:0])
            7'h37: begin r.op = OPENUM_LUI;   r.imm = w & 32'hFFFFF000; end
            7'h17: begin r.op = OPENUM_AUIPC; r.imm = w & 32'hFFFFF000; end
            7'h6F: begin r.op = OPENUM_JAL;   r.imm = 32'(j21); r.ctrl = 1; end
            7'h67: begin r.op = OPENUM_JALR;  r.imm = 32'(i12); r.ctrl = 1; end
            7'h03: begin r.op = LOAD_OPS[f3]; r.imm = 32'(i12); r.ls = 1; end
            7'h63: begin r.op = BR_OPS[f3];   r.imm = 32'(b13); r.ctrl = 1; r.rd = 0; end
            7'h23: begin r.op = ST_OPS[f3];   r.imm = 32'(s12); r.ls = 1; r.st = 1; r.rd = 0; end
            7'h13: begin
                r.op = AI_OPS[f3];
                if (f3 == 5 && alt) r.op = OPENUM_SRAI;
                r.imm = (f3 == 1 || f3 == 5) ? 32'(w[24:20]) : 32'(i12);
            end
            7'h33: begin
                r.op = AR_OPS[f3];
                if (f3 == 0 && alt) r.op = OPENUM_SUB;
                if (f3 == 5 && alt) r.op = OPENUM_SRA;
            end
            default: begin r.unk = 1; end
        endcase
        if (r.unk || r.op == OPENUM_NOP) begin
            r.ill = 1;
            r.op  = OPENUM_NOP;
        end
        return r;
    endfunction

    logic [63:0] q[$];

    task automatic check_all();
        ref_t r;
        check("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
        check("out_valid", 32'(out_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            r = ref_decode(q[0][31:0]);
            check("pc", out_pc, q[0][63:32]);
            check("openum", 32'(out_openum), 32'(r.op));
            check("rs1", 32'(out_rs1), 32'(q[0][19:15]));
            check("rs2", 32'(out_rs2), 32'(q[0][24:20]));
            check("illegal", 32'(out_illegal), 32'(r.ill));
            if (!r.ill || r.unk) begin
                check("rd", 32'(out_rd), r.unk ? 32'd0 : 32'(r.rd));
                check("is_ctrl", 32'(out_is_ctrl), 32'(r.ctrl));
                check("is_ls", 32'(out_is_ls), 32'(r.ls));
                check("is_store", 32'(out_is_store), 32'(r.st));
            end
            if (!r.ill) check("imm", out_imm, r.imm);
        end
    endtask

    // Drive one cycle, advance the model across the edge, then check.
    task automatic step(input logic rst, input logic rdy, input logic clr, input logic iv,
                        input logic [31:0] inst, input logic [31:0] pc, input logic ordy);
        bit do_push, do_pop;
        rst_in = rst; rdy_in = rdy; clear_in = clr; in_valid = iv;
        in_inst = inst; in_pc = pc; out_ready = ordy;
        if (rst) q.delete();
        else if (rdy) begin
            if (clr) q.delete();
            else begin
                do_push = iv && (q.size() < DEPTH);
                do_pop  = ordy && (q.size() != 0);
                if (do_pop) void'(q.pop_front());
                if (do_push) q.push_back({pc, inst});
            end
        end
        @(posedge clk_in);
        @(negedge clk_in);
        check_all();
    endtask

    localparam logic [6:0] OPCODES [10] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03,
                                            7'h63, 7'h23, 7'h13, 7'h33, 7'h7F};

    function automatic logic [31:0] rand_inst();
        logic [31:0] w;
        int k;
        w = $urandom;
        k = $urandom_range(0, 10);
        if (k < 10) w[6:0] = OPCODES[k];
        case ($urandom_range(0, 3))
            0: w[31:25] = 7'h00;
            1: w[31:25] = 7'h20;
            default: ;
        endcase
        return w;
    endfunction

    initial begin
        logic [31:0] pc;
        pc = 0;

        // Reset state: empty queue with zeroed decode outputs.
        step(1, 1, 0, 0, 0, 0, 0);
        check("rst_openum", 32'(out_openum), 32'(OPENUM_NOP));
        check("rst_rd", 32'(out_rd), 0);
        check("rst_imm", out_imm, 0);
        check("rst_illegal", 32'(out_illegal), 0);

        // ADDI x1,x0,-1 visible one cycle after the push.
        step(0, 1, 0, 1, 32'hFFF00093, 0, 0);
        check("addi_openum", 32'(out_openum), 32'(OPENUM_ADDI));
        check("addi_rd", 32'(out_rd), 1);
        check("addi_imm", out_imm, 32'hFFFFFFFF);

        // Fill to DEPTH, offer an extra (dropped), drain in order.
        step(1, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < DEPTH + 1; i++) step(0, 1, 0, 1, rand_inst(), 32'(i * 4), 0);
        check("full_in_ready", 32'(in_ready), 0);
        for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 0, 0, 0, 1);

        // Full queue with push+pop: pop only, then keep cycling across the wrap.
        for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 1, rand_inst(), 32'h100 + 32'(i * 4), 0);
        step(0, 1, 0, 1, rand_inst(), 32'h1FC, 1);
        check("pop_only_in_ready", 32'(in_ready), 1);
        for (int i = 0; i < 2 * DEPTH; i++) step(0, 1, 0, 1, rand_inst(), 32'h200 + 32'(i * 4), 1);

        // Specific decodes.
        step(1, 1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 1, 32'h12345097, 32'h40, 0);
        check("auipc_openum", 32'(out_openum), 32'(OPENUM_AUIPC));
        check("auipc_imm", out_imm, 32'h12345000);
        step(0, 1, 0, 1, 32'h4030D093, 32'h44, 1);
        check("srai_openum", 32'(out_openum), 32'(OPENUM_SRAI));
        check("srai_imm", out_imm, 3);
        step(0, 1, 0, 1, 32'h00112223, 32'h48, 1);
        check("sw_rd", 32'(out_rd), 0);
        check("sw_imm", out_imm, 4);
        check("sw_is_store", 32'(out_is_store), 1);

        // Push 3 then flush together with a push.
        step(1, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 1, rand_inst(), 32'(i * 4), 0);
        step(0, 1, 1, 1, rand_inst(), 32'h80, 1);
        check("flush_out_valid", 32'(out_valid), 0);

        // Stall holds state against push, pop and flush.
        step(0, 1, 0, 1, 32'h00000013, 32'hA0, 0);
        step(0, 1, 0, 1, 32'h00000033, 32'hA4, 0);
        step(0, 0, 1, 1, rand_inst(), 32'hA8, 1);
        step(0, 0, 0, 1, rand_inst(), 32'hAC, 1);
        check("hold_pc", out_pc, 32'hA0);

        // Unknown opcode.
        step(1, 1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 1, 32'h0000007F, 32'hC0, 0);
        check("ill_flag", 32'(out_illegal), 1);
        check("ill_openum", 32'(out_openum), 32'(OPENUM_NOP));

        // Randomized traffic with shifting fill/drain bias.
        for (int i = 0; i < 3000; i++) begin
            int pin, pout;
            pin  = ((i / 200) % 2 == 0) ? 80 : 30;
            pout = ((i / 200) % 2 == 0) ? 30 : 80;
            pc = pc + 4;
            step($urandom_range(0, 299) == 0, $urandom_range(0, 9) != 0,
                 $urandom_range(0, 79) == 0, $urandom_range(0, 99) < pin,
                 rand_inst(), pc, $urandom_range(0, 99) < pout);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
